systolic_skew_feeder: RTL and testbench
=======================================

// Module: systolic_skew_feeder
// PURPOSE
//  Upstream operand sequencer for the NxN output-stationary systolic array.
//  Accepts one A and one B matrix per job over a valid/ready handshake and latches both.
//  Emits the diagonally skewed per-lane vectors the array consumes, then drains with zeros.
//  Holds the array (en=0) and raises result_valid until the consumer takes the product from the array.
// PARAMETERS
//  N            2  array dimension (lanes per operand bus, matrix is NxN)
//  W           32  element width in bits, unsigned
//  DRAIN_CYCLES 3  zero-vector cycles after FEED so the last partial sums settle (>=1)
// PORTS
//  clock         in   1      rising-edge clock
//  reset_n       in   1      asynchronous, active-low reset
//  in_valid      in   1      a_mat/b_mat hold a job
//  in_ready      out  1      feeder can accept a job (IDLE only)
//  a_mat         in   N*N*W  [row][col][W] operand A
//  b_mat         in   N*N*W  [row][col][W] operand B
//  A             out  N*W    [lane][W] skewed A vector to array
//  B             out  N*W    [lane][W] skewed B vector to array
//  en            out  1      array advance enable
//  array_clear   out  1      one-cycle accumulator clear to array
//  result_valid  out  1      array Out holds completed A*B
//  result_ready  in   1      consumer has taken the result
//  busy          out  1      state != IDLE
// BEHAVIOUR
//  - One clock domain. reset_n is async-assert and sync-release. Reset forces state IDLE, cnt=0, latched mats=0.
//  - During reset: A=B=0, en=0, array_clear=0, result_valid=0, in_ready=0, busy=0.
//  - Every output is decoded from registered state, cnt and latched mats only. No input->output comb path.
//  - FSM: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
//  - IDLE: in_ready=1, en=0, A=B=0. On in_valid&&in_ready: latch a_mat/b_mat, go CLEAR.
//    a_mat/b_mat are ignored at all other times, so they may change once accepted.
//  - CLEAR (1 cycle): array_clear=1, en=0, A=B=0. Next state FEED with cnt=0.
//  - FEED (2N-1 cycles, cnt=t=0..2N-2): en=1.
//    Lane i of A: let d=t-i. If 0<=d<N, A[i]=a[i][N-1-d]; else A[i]=0.
//    Lane j of B: let d=t-j. If 0<=d<N, B[j]=b[N-1-d][j]; else B[j]=0.
//    At t=2N-2, go DRAIN with cnt=0.
//  - DRAIN (DRAIN_CYCLES cycles): en=1, A=B=0. Go DONE on the last count.
//  - DONE: en=0 (array holds), result_valid=1, A=B=0. On result_ready go IDLE.
//    A new job is not accepted in that same cycle; in_ready rises the cycle after.
//  - Latency: accept edge to result_valid = 2N+DRAIN_CYCLES cycles (7 for N=2, D=3).
//  - cnt is sized $clog2(max(2N-1,DRAIN_CYCLES)+1). No wrap occurs within a state.
//  - result_ready outside DONE and in_valid outside IDLE are ignored.
//  - busy=1 in CLEAR/FEED/DRAIN/DONE.
//  - Reset asserted mid-job aborts immediately to the reset values, and the job is lost.
//  - No arithmetic on data; elements pass through bit-exact.
// TESTING
//  1. Reset: hold reset_n=0 3 cycles, toggle in_valid -> A=B=0, en=0, in_ready=0.
//     Release -> in_ready=1 on the next cycle.
//  2. Skew: N=2, a=[[6,3],[5,4]], b=[[10,8],[2,1]].
//     FEED A lanes {l1,l0}: {0,3},{4,6},{5,0}; B lanes: {0,2},{1,10},{8,0}.
//  3. End to end with the array: same job -> result_valid after 7 cycles, Out=[[66,51],[58,44]].
//     Out is stable while result_ready=0 for 5 cycles.
//  4. Back-to-back: in_valid held high with a second job [[1,0],[0,1]]x[[7,8],[9,2]].
//     Second accept on the cycle after the DONE handshake. array_clear pulses once per job.
//     Second Out=[[7,8],[9,2]].
//  5. Abort: reset_n low during FEED t=1 -> outputs at reset values at once.
//     Fresh job after release completes correctly with no residue.
//  6. Ignored inputs: change a_mat after accept and pulse result_ready in FEED.
//     The emitted sequence is unchanged and the FSM does not skip DONE.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
//
// Operand sequencer for an NxN output-stationary systolic array. It accepts
// one A and one B matrix per job and latches both. It then clears the array
// and emits diagonally skewed lane vectors. After that it drains with zero
// vectors, and finally holds the array until the consumer takes the product.
//
// Ports
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset (synchronous release upstream)
//   in_valid      a_mat/b_mat hold a job
//   in_ready      feeder can accept a job (IDLE only)
//   a_mat, b_mat  NxN operands, element (r,c) at bits [(r*N+c)*W +: W]
//   A, B          skewed lane vectors, lane l at bits [l*W +: W]
//   en            array advance enable
//   array_clear   one-cycle accumulator clear
//   result_valid  array output holds the completed product
//   result_ready  consumer has taken the result
//   busy          feeder is not idle
//
// Every output is a flop loaded from the decode of the next registered
// state. The outputs therefore track the registered state exactly. There is
// no combinational path from any input to any output, and all outputs
// (including in_ready) read zero while reset is applied.
// ---------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int N            = 2,
  parameter int W            = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] a_mat,
  input  logic [N*N*W-1:0] b_mat,
  output logic [N*W-1:0]   A,
  output logic [N*W-1:0]   B,
  output logic             en,
  output logic             array_clear,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam int FEED_LEN = 2 * N - 1;
  localparam int CNT_MAX  = (FEED_LEN > DRAIN_CYCLES) ? FEED_LEN : DRAIN_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(FEED_LEN - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [N*N*W-1:0]   a_r, a_s, b_r, b_s;

  logic [N*W-1:0]     a_vec_r, a_vec_s, b_vec_r, b_vec_s;
  logic               in_ready_r, in_ready_s;
  logic               en_r, en_s;
  logic               clear_r, clear_s;
  logic               rvalid_r, rvalid_s;
  logic               busy_r, busy_s;

  // Lane i of A at time t carries row i, walking its columns from the last
  // one down to column 0. Lane i starts i cycles late, which gives the skew.
  function automatic logic [N*W-1:0] skew_a(input logic [CW-1:0] t,
                                            input logic [N*N*W-1:0] m);
    logic [N*W-1:0] v;
    int d;
    v = '0;
    for (int i = 0; i < N; i++) begin
      d = int'(t) - i;
      if ((d >= 0) && (d < N)) begin
        v[i*W +: W] = m[(i*N + (N - 1 - d))*W +: W];
      end else begin
        v[i*W +: W] = '0;
      end
    end
    return v;
  endfunction

  // Lane j of B at time t carries column j, walking its rows from the last
  // one up to row 0. This matches the k order used on the A side.
  function automatic logic [N*W-1:0] skew_b(input logic [CW-1:0] t,
                                            input logic [N*N*W-1:0] m);
    logic [N*W-1:0] v;
    int d;
    v = '0;
    for (int j = 0; j < N; j++) begin
      d = int'(t) - j;
      if ((d >= 0) && (d < N)) begin
        v[j*W +: W] = m[((N - 1 - d)*N + j)*W +: W];
      end else begin
        v[j*W +: W] = '0;
      end
    end
    return v;
  endfunction

  // Next-state, counter and operand-latch logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    a_s     = a_r;
    b_s     = b_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid && in_ready_r) begin
          state_s = S_CLEAR;
          cnt_s   = '0;
          a_s     = a_mat;
          b_s     = b_mat;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_s = S_FEED;
        cnt_s   = '0;
      end
      S_FEED: begin
        if (cnt_r == FEED_LAST) begin
          state_s = S_DRAIN;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_s = S_DONE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Output decode of the next state, loaded into the output flops below.
  always_comb begin
    in_ready_s = (state_s == S_IDLE);
    busy_s     = (state_s != S_IDLE);
    clear_s    = (state_s == S_CLEAR);
    en_s       = (state_s == S_FEED) || (state_s == S_DRAIN);
    rvalid_s   = (state_s == S_DONE);
    if (state_s == S_FEED) begin
      a_vec_s = skew_a(cnt_s, a_s);
      b_vec_s = skew_b(cnt_s, b_s);
    end else begin
      a_vec_s = '0;
      b_vec_s = '0;
    end
  end

  // State, counter and latched operands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      a_r     <= a_s;
      b_r     <= b_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      clear_r    <= 1'b0;
      en_r       <= 1'b0;
      rvalid_r   <= 1'b0;
      a_vec_r    <= '0;
      b_vec_r    <= '0;
    end else begin
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
      clear_r    <= clear_s;
      en_r       <= en_s;
      rvalid_r   <= rvalid_s;
      a_vec_r    <= a_vec_s;
      b_vec_r    <= b_vec_s;
    end
  end

  assign in_ready     = in_ready_r;
  assign busy         = busy_r;
  assign array_clear  = clear_r;
  assign en           = en_r;
  assign result_valid = rvalid_r;
  assign A            = a_vec_r;
  assign B            = b_vec_r;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_skew_feeder
//
// Directed bench for systolic_skew_feeder (N=2, W=32, DRAIN_CYCLES=3).
// A small output-stationary array model consumes A/B/en/array_clear.
// Expected per-cycle lane vectors and expected products are queued as each
// job is driven. They are popped when the feeder emits them.
// ---------------------------------------------------------------------------
module tb_systolic_skew_feeder;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int D  = 3;
  localparam int MW = N * N * W;
  localparam int PW = N * N * 64;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [MW-1:0]  a_mat;
  logic [MW-1:0]  b_mat;
  logic [N*W-1:0] A;
  logic [N*W-1:0] B;
  logic           en;
  logic           array_clear;
  logic           result_valid;
  logic           result_ready;
  logic           busy;

  int errors    = 0;
  int checks    = 0;
  int clear_cnt = 0;

  logic [2*N*W-1:0] skew_q[$];
  logic [PW-1:0]    out_q[$];

  logic [W-1:0]  pa  [N][N];
  logic [W-1:0]  pb  [N][N];
  logic [63:0]   acc [N][N];

  systolic_skew_feeder #(.N(N), .W(W), .DRAIN_CYCLES(D)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_mat        (a_mat),
    .b_mat        (b_mat),
    .A            (A),
    .B            (B),
    .en           (en),
    .array_clear  (array_clear),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] a_in(input int i, input int j);
    if (j == 0) return A[i*W +: W];
    else        return pa[i][j-1];
  endfunction

  function automatic logic [W-1:0] b_in(input int i, input int j);
    if (i == 0) return B[j*W +: W];
    else        return pb[i-1][j];
  endfunction

  // Output-stationary array: A flows right, B flows down, each PE accumulates.
  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (array_clear) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= 64'd0;
        end else if (en) begin
          pa[i][j]  <= a_in(i, j);
          pb[i][j]  <= b_in(i, j);
          acc[i][j] <= acc[i][j] + 64'(a_in(i, j)) * 64'(b_in(i, j));
        end
      end
    end
  end

  // Scoreboard: every en cycle must match the next queued lane vector pair.
  always @(negedge clock) begin
    if (reset_n && array_clear) clear_cnt <= clear_cnt + 1;
    if (reset_n && en) begin
      if (skew_q.size() == 0) chk("skew_extra_cycle", 256'd1, 256'd0);
      else                    chk("skew_vec", 256'({B, A}), 256'(skew_q.pop_front()));
    end
  end

  function automatic logic [MW-1:0] mk(input int e00, input int e01, input int e10, input int e11);
    logic [MW-1:0] m;
    m = '0;
    m[0*W +: W] = W'(e00);
    m[1*W +: W] = W'(e01);
    m[2*W +: W] = W'(e10);
    m[3*W +: W] = W'(e11);
    return m;
  endfunction

  function automatic logic [PW-1:0] mkp(input int p00, input int p01, input int p10, input int p11);
    logic [PW-1:0] p;
    p = '0;
    p[0*64 +: 64] = 64'(p00);
    p[1*64 +: 64] = 64'(p01);
    p[2*64 +: 64] = 64'(p10);
    p[3*64 +: 64] = 64'(p11);
    return p;
  endfunction

  function automatic logic [W-1:0] el(input logic [MW-1:0] m, input int r, input int c);
    return m[(r*N + c)*W +: W];
  endfunction

  function automatic logic [PW-1:0] out_now();
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        p[(i*N + j)*64 +: 64] = acc[i][j];
    return p;
  endfunction

  // Expected stream built from matrix elements: at time t lane l carries
  // k = N-1-(t-l) while that lies inside the matrix; then D zero vectors.
  task automatic push_skew(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [N*W-1:0] va, vb;
    for (int t = 0; t < 2*N-1; t++) begin
      va = '0;
      vb = '0;
      for (int l = 0; l < N; l++) begin
        if ((t - l >= 0) && (t - l < N)) begin
          va[l*W +: W] = el(a, l, N-1-(t-l));
          vb[l*W +: W] = el(b, N-1-(t-l), l);
        end
      end
      skew_q.push_back({vb, va});
    end
    for (int k = 0; k < D; k++) skew_q.push_back('0);
  endtask

  // First job's stream written out literally: {B l1,l0, A l1,l0}.
  task automatic push_job1();
    skew_q.push_back({32'd0, 32'd2,  32'd0, 32'd3});
    skew_q.push_back({32'd1, 32'd10, 32'd4, 32'd6});
    skew_q.push_back({32'd8, 32'd0,  32'd5, 32'd0});
    for (int k = 0; k < D; k++) skew_q.push_back('0);
    out_q.push_back(mkp(66, 51, 58, 44));
  endtask

  // Present a job and return at the negedge right after the accept edge.
  task automatic accept_job(input logic [MW-1:0] a, input logic [MW-1:0] b, output int waited);
    a_mat    = a;
    b_mat    = b;
    in_valid = 1'b1;
    waited   = 0;
    while ((in_ready !== 1'b1) && (waited < 40)) begin
      @(negedge clock);
      waited++;
    end
    chk("accept_in_ready", 256'(in_ready), 256'd1);
    @(negedge clock);
    in_valid = 1'b0;
    chk("accept_clear", 256'({array_clear, busy, in_ready, en}), 256'(4'b1100));
  endtask

  // Wait for the result, check latency and product, hold, then hand shake.
  task automatic finish_job(input int hold, input bit glitch, input bit nxt,
                            input logic [MW-1:0] na, input logic [MW-1:0] nb,
                            input logic [PW-1:0] nexp);
    int lat;
    logic [PW-1:0] expo;
    lat = 0;
    while ((result_valid !== 1'b1) && (lat < 40)) begin
      @(negedge clock);
      lat++;
      if (glitch) begin
        if (lat == 1) begin a_mat = ~a_mat; b_mat = ~b_mat; end
        if (lat == 2) result_ready = 1'b1;
        if (lat == 3) result_ready = 1'b0;
      end
    end
    chk("latency", 256'(lat), 256'd7);
    chk("skew_q_drained", 256'(skew_q.size()), 256'd0);
    if (out_q.size() == 0) begin
      chk("out_q_empty", 256'd1, 256'd0);
      expo = '0;
    end else begin
      expo = out_q.pop_front();
    end
    chk("out_product", 256'(out_now()), 256'(expo));
    chk("done_en_low", 256'({en, in_ready, busy}), 256'(3'b001));
    for (int h = 0; h < hold; h++) begin
      if ((h == 1) && nxt) begin
        push_skew(na, nb);
        out_q.push_back(nexp);
        a_mat    = na;
        b_mat    = nb;
        in_valid = 1'b1;
      end
      @(negedge clock);
      chk("hold_valid", 256'({result_valid, en, in_ready}), 256'(3'b100));
      chk("hold_out_stable", 256'(out_now()), 256'(expo));
    end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    chk("handshake_idle", 256'({result_valid, in_ready, busy}), 256'(3'b010));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] ja, jb, kb, ident;
    int w, c0;
    ja    = mk(6, 3, 5, 4);
    jb    = mk(10, 8, 2, 1);
    ident = mk(1, 0, 0, 1);
    kb    = mk(7, 8, 9, 2);

    // Reset held three cycles while in_valid toggles.
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    result_ready = 1'b0;
    a_mat        = ja;
    b_mat        = jb;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      in_valid = ~in_valid;
      #1;
      chk("reset_outputs", 256'({A, B, en, array_clear, result_valid, in_ready, busy}), 256'd0);
    end
    @(negedge clock);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    chk("release_in_ready_low", 256'(in_ready), 256'd0);
    @(negedge clock);
    chk("release_in_ready_high", 256'({in_ready, busy}), 256'(2'b10));

    // Skew and end-to-end product, with a back-to-back second job queued.
    c0 = clear_cnt;
    push_job1();
    accept_job(ja, jb, w);
    finish_job(5, 1'b0, 1'b1, ident, kb, mkp(7, 8, 9, 2));
    accept_job(ident, kb, w);
    chk("b2b_accept_immediate", 256'(w), 256'd0);
    finish_job(2, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("clear_once_per_job", 256'(clear_cnt - c0), 256'd2);

    // Abort during FEED t=1, then a fresh job.
    push_job1();
    accept_job(ja, jb, w);
    @(negedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", 256'({A, B, en, array_clear, result_valid, in_ready, busy}), 256'd0);
    skew_q.delete();
    out_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("abort_release_ready", 256'(in_ready), 256'd1);
    push_job1();
    accept_job(ja, jb, w);
    finish_job(1, 1'b0, 1'b0, '0, '0, '0);

    // Operands changed after accept and result_ready pulsed during FEED.
    push_skew(ident, kb);
    out_q.push_back(mkp(7, 8, 9, 2));
    accept_job(ident, kb, w);
    finish_job(1, 1'b1, 1'b0, '0, '0, '0);

    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
